// File: rtl/rst_sync_seq_if.sv
// -----------------------------------------------------------------------------
// rst_sync_seq_if
//   Bundles the sequencer's request/status signals so a reset-tree root can be
//   hooked up with a single port.
//
//   Parameters
//     NUM_RST     width of the sequenced reset vector
//
//   Signals
//     sw_rst_req  synchronous software reset request, active high, level sampled
//     rstn_out    sequenced active-low resets, bit 0 released first
//     rst_done    high once every rstn_out bit is released
//     evt_cnt     software reset event count (zero when the counter is built out)
//     dbg_state   current sequencer state, for observation only
//
//   Modports
//     master      requester / consumer side (drives sw_rst_req)
//     slave       sequencer side (drives the status outputs)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface rst_sync_seq_if #(
    parameter int NUM_RST = 4
);
    logic               sw_rst_req;
    logic [NUM_RST-1:0] rstn_out;
    logic               rst_done;
    logic [7:0]         evt_cnt;
    logic [1:0]         dbg_state;

    modport master (
        output sw_rst_req,
        input  rstn_out,
        input  rst_done,
        input  evt_cnt,
        input  dbg_state
    );

    modport slave (
        input  sw_rst_req,
        output rstn_out,
        output rst_done,
        output evt_cnt,
        output dbg_state
    );
endinterface

// File: rtl/rst_sync_seq.sv
// -----------------------------------------------------------------------------
// rst_sync_seq
//   Reset synchroniser and staggered release sequencer for the root of one
//   clock domain's reset tree.
//
//   rstn_async asserts every output at once (no clock needed). Its release
//   passes through a SYNC_STAGES flop chain; the chain's last stage
//   (rst_sync_n) then holds the sequencer in reset. After rst_sync_n rises all
//   outputs stay low for MIN_ASSERT more edges, then rstn_out[0] is released
//   and each further bit follows STAGGER edges after the previous one. The
//   edge releasing the last bit also raises rst_done.
//
//   A high sw_rst_req sampled on any edge drops every output on that edge and
//   restarts the hold period; holding it high keeps the outputs low.
//
//   Ports
//     clk         domain clock
//     rstn_async  asynchronous active-low reset
//     bus         rst_sync_seq_if.slave: sw_rst_req in; rstn_out, rst_done,
//                 evt_cnt, dbg_state out
//
//   Parameters
//     SYNC_STAGES synchroniser depth on the release path (>= 2)
//     NUM_RST     number of sequenced outputs (>= 1)
//     MIN_ASSERT  hold cycles after synced release or sw request (>= 1)
//     STAGGER     cycles between consecutive releases (>= 1)
//
//   Build option
//     RSTSEQ_EVT_CNT_EN  when defined, evt_cnt counts edges with sw_rst_req
//                        high, saturating at 255 and cleared only by
//                        rstn_async. When undefined evt_cnt is tied to zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rst_sync_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_RST     = 4,
    parameter int MIN_ASSERT  = 4,
    parameter int STAGGER     = 3
) (
    input  logic           clk,
    input  logic           rstn_async,
    rst_sync_seq_if.slave  bus
);

    localparam int CNT_MAX = (MIN_ASSERT > STAGGER) ? MIN_ASSERT : STAGGER;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]      MA_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0]      ST_LAST = CW'(STAGGER - 1);
    localparam logic [NUM_RST-1:0] LSB     = NUM_RST'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Release synchroniser: assertion is immediate, release is clocked.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync_n;

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_RST-1:0] rstn_q, rstn_d;
    logic               done_q, done_d;

    // Cleared by the synchronised reset so that rstn_async still takes the
    // outputs low immediately (it clears sync_q, hence rst_sync_n, at once).
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rstn_d  = rstn_q;
        done_d  = done_q;

        if (bus.sw_rst_req) begin
            // Any state: drop everything and restart the hold period.
            state_d = ST_ASSERT;
            cnt_d   = '0;
            rstn_d  = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == MA_LAST) begin
                        cnt_d  = '0;
                        rstn_d = LSB;
                        if (NUM_RST == 1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == ST_LAST) begin
                        cnt_d  = '0;
                        // Released bits form a contiguous run from bit 0, so
                        // shifting in a one releases the next bit in order.
                        rstn_d = (rstn_q << 1) | LSB;
                        if (rstn_d[NUM_RST-1]) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                ST_DONE: begin
                    rstn_d = '1;
                    done_d = 1'b1;
                end

                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    rstn_d  = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.rstn_out  = rstn_q;
    assign bus.rst_done  = done_q;
    assign bus.dbg_state = state_q;

    // ------------------------------------------------------------------
    // Software reset event counter
    // ------------------------------------------------------------------
`ifdef RSTSEQ_EVT_CNT_EN
    logic [7:0] evt_q;

    // Cleared by rstn_async directly: the count survives sw requests and is
    // kept through the synchroniser release window.
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            evt_q <= 8'd0;
        end else if (bus.sw_rst_req && (evt_q != 8'd255)) begin
            evt_q <= evt_q + 8'd1;
        end
    end

    assign bus.evt_cnt = evt_q;
`else
    assign bus.evt_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rst_sync_seq.sv
// -----------------------------------------------------------------------------
// tb_rst_sync_seq
//   Directed bench for rst_sync_seq. A default-parameter instance and a
//   NUM_RST=1 / MIN_ASSERT=1 / STAGGER=1 instance share clk, rstn_async and
//   sw_rst_req. A time-ordered table of {apply time, inputs, expected outputs}
//   drives and checks both; a hand-written sequence then covers counter
//   saturation and its clear by rstn_async.
//   Clock: period 10 ns, clk=1 at t=0, rising edges at t=10,20,...
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rst_sync_seq;

`ifdef RSTSEQ_EVT_CNT_EN
    localparam bit EVT_ON = 1'b1;
`else
    localparam bit EVT_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b1;
    logic rstn_async;

    always #5 clk = ~clk;

    rst_sync_seq_if #(.NUM_RST(4)) bus  ();
    rst_sync_seq_if #(.NUM_RST(1)) bus1 ();

    rst_sync_seq #(
        .SYNC_STAGES (2),
        .NUM_RST     (4),
        .MIN_ASSERT  (4),
        .STAGGER     (3)
    ) dut (
        .clk        (clk),
        .rstn_async (rstn_async),
        .bus        (bus.slave)
    );

    rst_sync_seq #(
        .SYNC_STAGES (2),
        .NUM_RST     (1),
        .MIN_ASSERT  (1),
        .STAGGER     (1)
    ) dut1 (
        .clk        (clk),
        .rstn_async (rstn_async),
        .bus        (bus1.slave)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         t;      // time inputs are applied; outputs checked 1 ns later
        logic       rstn;
        logic       sw;
        logic [3:0] big;    // expected rstn_out of the default instance
        logic       done;
        logic [7:0] evt;
        logic       sm;     // expected rstn_out of the single-output instance
        logic       smd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int t, input logic rstn, input logic sw,
                       input logic [3:0] big, input logic done, input logic [7:0] evt,
                       input logic sm, input logic smd);
        vec_t v;
        v.t = t; v.rstn = rstn; v.sw = sw;
        v.big = big; v.done = done; v.evt = evt; v.sm = sm; v.smd = smd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rstn, input logic sw);
        rstn_async      = rstn;
        bus.sw_rst_req  = sw;
        bus1.sw_rst_req = sw;
    endtask

    task automatic check_all(input string tag, input logic [3:0] big, input logic done,
                             input logic [7:0] evt, input logic sm, input logic smd);
        check({tag, " rstn_out"},  {4'b0, bus.rstn_out}, {4'b0, big});
        check({tag, " rst_done"},  {7'b0, bus.rst_done}, {7'b0, done});
        check({tag, " evt_cnt"},   bus.evt_cnt, evt);
        check({tag, " rstn_out1"}, {7'b0, bus1.rstn_out}, {7'b0, sm});
        check({tag, " rst_done1"}, {7'b0, bus1.rst_done}, {7'b0, smd});
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0] ev1, ev2, ev6, ev_sat;
        ev1    = EVT_ON ? 8'd1   : 8'd0;
        ev2    = EVT_ON ? 8'd2   : 8'd0;
        ev6    = EVT_ON ? 8'd6   : 8'd0;
        ev_sat = EVT_ON ? 8'd255 : 8'd0;

        drive(1'b0, 1'b0);

        // Power-up: release at t4 -> E0=t20; bits at 60/90/120/150.
        // Single-output instance releases at E0+1 = t30.
        add(  1, 0, 0, 4'b0000, 0, 0,   0, 0);
        add(  4, 1, 0, 4'b0000, 0, 0,   0, 0);
        add( 25, 1, 0, 4'b0000, 0, 0,   0, 0);
        add( 31, 1, 0, 4'b0000, 0, 0,   1, 1);
        add( 55, 1, 0, 4'b0000, 0, 0,   1, 1);
        add( 61, 1, 0, 4'b0001, 0, 0,   1, 1);
        add( 85, 1, 0, 4'b0001, 0, 0,   1, 1);
        add( 91, 1, 0, 4'b0011, 0, 0,   1, 1);
        add(121, 1, 0, 4'b0111, 0, 0,   1, 1);
        add(145, 1, 0, 4'b0111, 0, 0,   1, 1);
        add(151, 1, 0, 4'b1111, 1, 0,   1, 1);
        // Runt low pulse t163..167 with no edge inside: full reset.
        // Release -> E0=t180; big bit0 t220, bit1 t250; small t190.
        add(163, 0, 0, 4'b0000, 0, 0,   0, 0);
        add(167, 1, 0, 4'b0000, 0, 0,   0, 0);
        add(185, 1, 0, 4'b0000, 0, 0,   0, 0);
        add(191, 1, 0, 4'b0000, 0, 0,   1, 1);
        add(215, 1, 0, 4'b0000, 0, 0,   1, 1);
        add(221, 1, 0, 4'b0001, 0, 0,   1, 1);
        add(251, 1, 0, 4'b0011, 0, 0,   1, 1);
        add(255, 1, 0, 4'b0011, 0, 0,   1, 1);
        // Mid-sequence abort t257..271: outputs drop at once.
        // E0=t290; bit0 t330, bit3+done t420; small t300.
        add(257, 0, 0, 4'b0000, 0, 0,   0, 0);
        add(271, 1, 0, 4'b0000, 0, 0,   0, 0);
        add(295, 1, 0, 4'b0000, 0, 0,   0, 0);
        add(301, 1, 0, 4'b0000, 0, 0,   1, 1);
        add(325, 1, 0, 4'b0000, 0, 0,   1, 1);
        add(331, 1, 0, 4'b0001, 0, 0,   1, 1);
        add(415, 1, 0, 4'b0111, 0, 0,   1, 1);
        add(421, 1, 0, 4'b1111, 1, 0,   1, 1);
        // One-cycle sw request sampled at t500 in DONE.
        // bit0 t540, bit3+done t630; small t510.
        add(495, 1, 1, 4'b1111, 1, 0,   1, 1);
        add(505, 1, 0, 4'b0000, 0, ev1, 0, 0);
        add(511, 1, 0, 4'b0000, 0, ev1, 1, 1);
        add(535, 1, 0, 4'b0000, 0, ev1, 1, 1);
        add(541, 1, 0, 4'b0001, 0, ev1, 1, 1);
        add(625, 1, 0, 4'b0111, 0, ev1, 1, 1);
        add(631, 1, 0, 4'b1111, 1, ev1, 1, 1);
        // sw request held over edges t700..t740 (5 samples).
        // bit0 t780, done t870; small t750; evt +5.
        add(695, 1, 1, 4'b1111, 1, ev1, 1, 1);
        add(701, 1, 1, 4'b0000, 0, ev2, 0, 0);
        add(745, 1, 0, 4'b0000, 0, ev6, 0, 0);
        add(751, 1, 0, 4'b0000, 0, ev6, 1, 1);
        add(775, 1, 0, 4'b0000, 0, ev6, 1, 1);
        add(781, 1, 0, 4'b0001, 0, ev6, 1, 1);
        add(865, 1, 0, 4'b0111, 0, ev6, 1, 1);
        add(871, 1, 0, 4'b1111, 1, ev6, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].t > int'($time)) #(vecs[i].t - int'($time));
            drive(vecs[i].rstn, vecs[i].sw);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].big, vecs[i].done,
                      vecs[i].evt, vecs[i].sm, vecs[i].smd);
        end

        // Saturation: sw held for 300 edges (t900..t3890).
        #(895 - int'($time));
        drive(1'b1, 1'b1);
        repeat (300) @(posedge clk);
        @(negedge clk);
        check_all("sat_hold", 4'b0000, 1'b0, ev_sat, 1'b0, 1'b0);
        drive(1'b1, 1'b0);
        // Last sample t3890: bit0 t3930, done t4020; check at t4035.
        repeat (14) @(posedge clk);
        @(negedge clk);
        check_all("sat_done", 4'b1111, 1'b1, ev_sat, 1'b1, 1'b1);

        // rstn_async pulse clears the counter and the outputs immediately.
        drive(1'b0, 1'b0);
        #1;
        check_all("pulse_low", 4'b0000, 1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        drive(1'b1, 1'b0);
        // 2 sync + 4 hold + 9 stagger edges to done; allow margin.
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_all("pulse_done", 4'b1111, 1'b1, 8'd0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
